// File: rtl/bcd_chain_issuer_pkg.sv
// Shared definitions for the BCD chain issue stage: state encoding,
// op code values understood by the chain elements and gauss_op codes.
package bcd_chain_issuer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } issue_state_t;

    // Op codes seen by every chain element; OP_NOP makes an element hold r.
    localparam int OP_NOP    = 0;
    localparam int OP_GAUSS  = 1;
    localparam int OP_KEYMUL = 7;

    // gauss_op codes: pass-through, load pivot product, accumulate.
    localparam logic [1:0] GAUSS_PASS = 2'b00;
    localparam logic [1:0] GAUSS_LOAD = 2'b01;
    localparam logic [1:0] GAUSS_ADD  = 2'b10;

endpackage

// File: rtl/bcd_issue_ctr.sv
// Loadable down-counter; saturates at zero so an extra dec is harmless.
module bcd_issue_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    // Load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bcd_chain_issuer.sv
// Issue stage feeding element 0 of a BCD processing chain.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_ISSUE | streaming beats into the chain head, din_ready high
//   ST_DRAIN | bubbles while the chain flushes (DRAIN_CYCLES cycles)
//   ST_DONE  | one-cycle done pulse, back to ST_IDLE
module bcd_chain_issuer
    import bcd_chain_issuer_pkg::*;
#(
    parameter int GF_BIT       = 4,
    parameter int OP_CODE_LEN  = 4,
    parameter int LEN_W        = 8,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_CODE_LEN-1:0] cmd_op,
    input  logic [1:0]             cmd_gauss,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [GF_BIT-1:0]      din_data,
    input  logic [GF_BIT-1:0]      din_b,
    input  logic [GF_BIT-1:0]      din_a,
    output logic                   start_out,
    output logic [OP_CODE_LEN-1:0] op_out,
    output logic [1:0]             gauss_op_out,
    output logic [GF_BIT-1:0]      data_out,
    output logic [GF_BIT-1:0]      dataB_out,
    output logic [GF_BIT-1:0]      dataA_out,
    output logic                   busy,
    output logic                   done
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    issue_state_t state_q, state_d;

    logic [OP_CODE_LEN-1:0] op_q;
    logic [1:0]             gauss_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       beat_rem;
    logic [DRN_W-1:0]       drain_cnt;

    logic cmd_fire, beat_fire, beat_first, beat_last, drain_zero;
    logic drain_load, drain_dec;

    // Remaining beats of the current command; beat 0 is the one seen while
    // nothing has been consumed yet, so stalls never re-raise start.
    bcd_issue_ctr #(.W(LEN_W)) u_beat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (cmd_fire),
        .load_val (cmd_len),
        .dec      (beat_fire),
        .count    (beat_rem)
    );

    bcd_issue_ctr #(.W(DRN_W)) u_drain_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (drain_dec),
        .count    (drain_cnt)
    );

    // Handshakes, counter controls and next state.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = (state_q == ST_IDLE) && !rst;
        din_ready  = (state_q == ST_ISSUE) && !rst;
        cmd_fire   = cmd_valid && cmd_ready;
        beat_fire  = din_valid && din_ready;
        beat_first = (beat_rem == len_q);
        beat_last  = (beat_rem == LEN_W'(1));
        drain_zero = (drain_cnt == '0);
        drain_load = (cmd_fire && (cmd_len == '0)) || (beat_fire && beat_last);
        drain_dec  = (state_q == ST_DRAIN) && !drain_zero;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_len == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat_fire && beat_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields are captured once and applied to every beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            gauss_q <= '0;
            len_q   <= '0;
        end else if (cmd_fire) begin
            op_q    <= cmd_op;
            gauss_q <= cmd_gauss;
            len_q   <= cmd_len;
        end
    end

    // Registered chain-head outputs: a beat or a bubble every cycle.
    always_ff @(posedge clk) begin
        if (rst || !beat_fire) begin
            start_out    <= 1'b0;
            op_out       <= OP_CODE_LEN'(OP_NOP);
            gauss_op_out <= GAUSS_PASS;
            data_out     <= '0;
            dataB_out    <= '0;
            dataA_out    <= '0;
        end else begin
            start_out    <= beat_first;
            op_out       <= op_q;
            gauss_op_out <= beat_first ? GAUSS_LOAD : gauss_q;
            data_out     <= din_data;
            dataB_out    <= din_b;
            dataA_out    <= din_a;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_chain_issuer.sv
// Randomized bench for bcd_chain_issuer with a transaction-level reference.
module tb_bcd_chain_issuer;

    localparam int GF  = 4;
    localparam int OPL = 4;
    localparam int LW  = 8;
    localparam int D   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [OPL-1:0] cmd_op;
    logic [1:0]    cmd_gauss;
    logic [LW-1:0] cmd_len;
    logic          din_valid, din_ready;
    logic [GF-1:0] din_data, din_b, din_a;
    logic          start_out;
    logic [OPL-1:0] op_out;
    logic [1:0]    gauss_op_out;
    logic [GF-1:0] data_out, dataB_out, dataA_out;
    logic          busy, done;

    always #5 clk = ~clk;

    bcd_chain_issuer #(
        .GF_BIT(GF), .OP_CODE_LEN(OPL), .LEN_W(LW), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_gauss(cmd_gauss), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_b(din_b), .din_a(din_a),
        .start_out(start_out), .op_out(op_out), .gauss_op_out(gauss_op_out),
        .data_out(data_out), .dataB_out(dataB_out), .dataA_out(dataA_out),
        .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference: where the current command is in its life, as plain counts.
    bit   m_idle = 1'b1;
    bit   m_issue = 1'b0;
    bit   m_done = 1'b0;
    int   m_left = 0, m_sent = 0, m_drain = 0;
    bit   m_acc = 1'b0;
    int   m_acc_cyc = 0;
    int   last_done_cyc = -1;
    logic [OPL-1:0] m_op = '0;
    logic [1:0]     m_g = '0;
    logic [31:0]    m_out = '0;

    function automatic logic [31:0] pack_out(logic s, logic [OPL-1:0] o, logic [1:0] g,
                                             logic [GF-1:0] d, logic [GF-1:0] b, logic [GF-1:0] a);
        return 32'({s, o, g, d, b, a});
    endfunction

    task automatic model_check();
        chk("cmd_ready", 32'(cmd_ready), 32'(!rst && m_idle));
        chk("din_ready", 32'(din_ready), 32'(!rst && m_issue));
        chk("busy",      32'(busy),      32'(!m_idle));
        chk("done",      32'(done),      32'(m_done));
        chk("chain_out", pack_out(start_out, op_out, gauss_op_out, data_out, dataB_out, dataA_out), m_out);
        if (done) last_done_cyc = cyc;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_idle = 1'b1; m_issue = 1'b0; m_done = 1'b0;
            m_left = 0; m_sent = 0; m_drain = 0; m_out = '0;
        end else begin
            m_out = '0;
            if (m_done) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end else if (m_idle) begin
                if (cmd_valid) begin
                    m_op = cmd_op; m_g = cmd_gauss;
                    m_idle = 1'b0; m_acc = 1'b1; m_acc_cyc = cyc;
                    if (cmd_len == 0) begin
                        m_drain = D;
                    end else begin
                        m_issue = 1'b1; m_left = int'(cmd_len); m_sent = 0;
                    end
                end
            end else if (m_issue) begin
                if (din_valid) begin
                    m_out = pack_out(m_sent == 0, m_op, (m_sent == 0) ? 2'b01 : m_g,
                                     din_data, din_b, din_a);
                    m_sent++; m_left--;
                    if (m_left == 0) begin
                        m_issue = 1'b0; m_drain = D;
                    end
                end
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_done = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_lanes();
        din_data = GF'($urandom);
        din_b    = GF'($urandom);
        din_a    = GF'($urandom);
    endtask

    task automatic new_cmd(input int op, input int g, input int len);
        cmd_valid = 1'b1;
        cmd_op    = OPL'(op);
        cmd_gauss = 2'(g);
        cmd_len   = LW'(len);
        m_acc     = 1'b0;
    endtask

    int stall;
    int budget;

    initial begin
        rst = 1'b1; din_valid = 1'b0; din_data = '0; din_b = '0; din_a = '0;
        new_cmd(1, 2, 3);
        @(posedge clk); #1;
        model_edge();
        cyc++;

        // Reset held with cmd_valid high.
        repeat (3) step();
        rst = 1'b0;

        // Basic command: beats 5,6,7 back-to-back.
        din_valid = 1'b1;
        repeat (3 + D + 6) begin
            din_data = GF'(5 + m_sent); din_b = GF'($urandom); din_a = GF'($urandom);
            step();
            if (m_acc) cmd_valid = 1'b0;
        end

        // Stall two cycles between beats 1 and 2.
        new_cmd(1, 2, 3);
        stall = 0;
        repeat (3 + D + 10) begin
            rand_lanes();
            din_valid = !(m_issue && m_sent == 2 && stall < 2);
            if (m_issue && m_sent == 2 && stall < 2) stall++;
            step();
            if (m_acc) cmd_valid = 1'b0;
        end

        // len = 0: done exactly D+1 cycles after accept.
        new_cmd(7, 2, 0);
        din_valid = 1'b1;
        last_done_cyc = -1;
        repeat (D + 5) begin
            rand_lanes();
            step();
            if (m_acc) cmd_valid = 1'b0;
        end
        chk("len0_latency", 32'(last_done_cyc - m_acc_cyc), 32'(D + 1));

        // Reset in the middle of a 4-beat command.
        new_cmd(1, 2, 4);
        budget = 20;
        while (!(m_issue && m_sent == 1) && budget > 0) begin
            rand_lanes();
            step();
            if (m_acc) cmd_valid = 1'b0;
            budget--;
        end
        chk("reach_beat1", 32'(budget > 0), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        new_cmd(1, 1, 2);
        repeat (D + 8) begin
            rand_lanes();
            step();
            if (m_acc) cmd_valid = 1'b0;
        end

        // Back-to-back commands, next one always offered.
        new_cmd(1, 2, 2);
        repeat (3 * (D + 6)) begin
            rand_lanes();
            din_valid = ($urandom % 4) != 0;
            step();
            if (m_acc) new_cmd(int'($urandom % 8), int'($urandom % 3), int'(1 + $urandom % 3));
        end

        // Random traffic with occasional resets.
        new_cmd(int'($urandom % 16), int'($urandom % 4), int'($urandom % 7));
        repeat (3000) begin
            rand_lanes();
            din_valid = ($urandom % 4) != 0;
            rst = ($urandom % 150) == 0;
            if (!cmd_valid && ($urandom % 3) == 0) begin
                new_cmd(int'($urandom % 16), int'($urandom % 4), int'($urandom % 7));
            end
            step();
            if (m_acc) begin
                cmd_valid = 1'b0;
                m_acc = 1'b0;
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
